ysyx_23060201_seq_ctrl: RTL and testbench
=========================================

// Module: ysyx_23060201_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the single-issue core: fetch, execute, optional memory, commit.
//  Drives the IFU fetch handshake and latches the instruction for IDU/EXU.
//  Gates the EXU register write into a one-cycle commit pulse and owns the PC register.
//  Issues the LSU handshake for loads/stores; halts on ebreak; traps bus timeouts.
// PARAMETERS
//  RESET_PC     32'h8000_0000  PC loaded on reset
//  TIMEOUT_CYC  16             max wait cycles for an IFU/LSU response; 0 disables the watchdog
// PORTS
//  clk            in   1   core clock; all state updates on posedge
//  rst            in   1   synchronous reset, active-high
//  ifu_req_valid  out  1   fetch request valid
//  ifu_req_ready  in   1   IFU accepts request
//  ifu_addr       out  32  fetch address (= pc)
//  ifu_rsp_valid  in   1   instruction data valid
//  ifu_rsp_data   in   32  instruction word
//  inst           out  32  latched instruction to IDU/EXU
//  is_mem         in   1   decoded load/store (from IDU, valid in EXEC)
//  is_store       in   1   decoded store
//  is_ebreak      in   1   decoded ebreak
//  exu_wen        in   1   EXU register-write request
//  exu_dnpc       in   32  EXU next PC
//  lsu_req_valid  out  1   memory request valid
//  lsu_req_ready  in   1   LSU accepts request
//  lsu_rsp_valid  in   1   LSU done (load data valid / store acked)
//  gpr_wen        out  1   one-cycle commit write enable to GPR file
//  pc             out  32  current PC
//  halt           out  1   sticky, set on ebreak
//  err            out  1   sticky, set on timeout or misaligned dnpc
//  cycle_cnt      out  64  performance counter (see CONFIGURATION)
//  instret_cnt    out  64  retired-instruction counter
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, inst=0, all valids=0, gpr_wen=0, halt=0, err=0, counters=0.
//   rst mid-transaction aborts it at once; responses arriving afterwards are ignored.
//  States: IDLE, FETCH, WAIT_I, EXEC, MEM_REQ, MEM_WAIT, HALT, ERR.
//  IDLE:     -> FETCH on the next cycle.
//  FETCH:    ifu_req_valid=1, ifu_addr=pc, both held stable until ifu_req_ready; handshake -> WAIT_I.
//  WAIT_I:   on ifu_rsp_valid: inst<=ifu_rsp_data -> EXEC. Response is accepted no earlier than
//            the cycle after the request handshake. rsp_valid in any other state is ignored.
//  EXEC:     one cycle; decode inputs are sampled here. Priority order:
//             is_ebreak: -> HALT, no write, pc unchanged.
//             exu_dnpc[1:0]!=0: -> ERR, no write.
//             is_mem: -> MEM_REQ.
//             otherwise commit: gpr_wen=exu_wen, pc<=exu_dnpc, -> FETCH.
//  MEM_REQ:  lsu_req_valid=1 until lsu_req_ready; handshake -> MEM_WAIT.
//  MEM_WAIT: on lsu_rsp_valid commit: gpr_wen=exu_wen&~is_store, pc<=exu_dnpc, -> FETCH.
//  Commit: gpr_wen is high exactly one cycle per retired instruction; 0 in all other states.
//  Latency: non-mem instruction takes 3 cycles with zero-wait IFU (FETCH, WAIT_I, EXEC).
//  Watchdog: wait counter clears on entry to WAIT_I/MEM_WAIT and increments each cycle without
//   a response. Reaching TIMEOUT_CYC -> ERR. A response in the same cycle wins over the timeout.
//  HALT and ERR are absorbing until rst. All outputs except pc/inst/halt/err are 0 there.
//  pc arithmetic is modulo 2^32; exu_dnpc is used verbatim.
// CONFIGURATION
//  YSYX_23060201_PERF_CNT_EN defined:
//   - cycle_cnt increments every cycle the state is not IDLE/HALT/ERR.
//   - instret_cnt increments on each gpr commit cycle (stores/no-write ops included).
//   - Both are 64-bit, wrap to 0, and clear on rst.
//  Undefined: both ports are tied to 0 and no counter flops are built.
// TESTING
//  1 Reset, zero-wait IFU, addi (exu_wen=1, dnpc=pc+4) -> ifu_addr=0x80000000, gpr_wen pulse
//    on cycle 3 after IDLE exit, pc=0x80000004.
//  2 jal: dnpc=0x80000010 -> next ifu_addr=0x80000010. dnpc=0x80000012 -> err=1, gpr_wen never high.
//  3 Load, lsu_req_ready delayed 2 cycles, rsp 1 cycle later -> lsu_req_valid held 3 cycles,
//    single gpr_wen. Store: same timing with gpr_wen=0 and pc advances.
//  4 ebreak -> halt=1 after EXEC; ifu_req_valid stays 0 for 20 further cycles; pc unchanged.
//  5 IFU never responds, TIMEOUT_CYC=16 -> err=1 after 16 WAIT_I cycles.
//    Response on cycle 16 -> no error.
//  6 rst asserted in MEM_WAIT, then late lsu_rsp_valid -> state IDLE, pc=RESET_PC, no gpr_wen;
//    with PERF_CNT_EN, after 10 addi instret_cnt=10.

Source files
------------

// File: rtl/ysyx_23060201_seq_ctrl_if.sv
// Fetch (IFU) and memory (LSU) handshake bundle between the sequencer and the bus side.
// master = sequencer, slave = IFU/LSU responder.
interface ysyx_23060201_seq_ctrl_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;

  modport master (
    output ifu_req_valid, ifu_addr, lsu_req_valid,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, lsu_req_ready, lsu_rsp_valid
  );

  modport slave (
    input  ifu_req_valid, ifu_addr, lsu_req_valid,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, lsu_req_ready, lsu_rsp_valid
  );
endinterface

// File: rtl/ysyx_23060201_seq_ctrl.sv
// Multi-cycle fetch/execute/memory/commit sequencer owning the PC, with bus watchdog.
// Optional performance counters enabled by YSYX_23060201_PERF_CNT_EN.
module ysyx_23060201_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  ysyx_23060201_seq_ctrl_if.master        bus,
  output logic [31:0]                     inst,
  input  logic                            is_mem,
  input  logic                            is_store,
  input  logic                            is_ebreak,
  input  logic                            exu_wen,
  input  logic [31:0]                     exu_dnpc,
  output logic                            gpr_wen,
  output logic [31:0]                     pc,
  output logic                            halt,
  output logic                            err,
  output logic [63:0]                     cycle_cnt,
  output logic [63:0]                     instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_I,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state, state_nx;
  logic [31:0] pc_nx;
  logic [31:0] inst_nx;
  logic [31:0] wait_cnt, wait_cnt_nx;
  logic        mem_wen_q, mem_wen_nx;
  logic [31:0] mem_dnpc_q, mem_dnpc_nx;
  logic        timeout_hit;

  // The last silent wait cycle trips the watchdog; a response in that cycle still wins.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nx          = state;
    pc_nx             = pc;
    inst_nx           = inst;
    wait_cnt_nx       = wait_cnt;
    mem_wen_nx        = mem_wen_q;
    mem_dnpc_nx       = mem_dnpc_q;
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = pc;
    bus.lsu_req_valid = 1'b0;
    gpr_wen           = 1'b0;

    unique case (state)
      S_IDLE: state_nx = S_FETCH;

      S_FETCH: begin
        bus.ifu_req_valid = 1'b1;
        if (bus.ifu_req_ready) begin
          state_nx    = S_WAIT_I;
          wait_cnt_nx = '0;
        end
      end

      S_WAIT_I: begin
        if (bus.ifu_rsp_valid) begin
          inst_nx  = bus.ifu_rsp_data;
          state_nx = S_EXEC;
        end else if (timeout_hit) begin
          state_nx = S_ERR;
        end else begin
          wait_cnt_nx = wait_cnt + 32'd1;
        end
      end

      S_EXEC: begin
        if (is_ebreak) begin
          state_nx = S_HALT;
        end else if (exu_dnpc[1:0] != 2'b00) begin
          state_nx = S_ERR;
        end else if (is_mem) begin
          // Decode is only guaranteed in EXEC, so the commit is captured for MEM_WAIT.
          mem_wen_nx  = exu_wen & ~is_store;
          mem_dnpc_nx = exu_dnpc;
          state_nx    = S_MEM_REQ;
        end else begin
          gpr_wen  = exu_wen;
          pc_nx    = exu_dnpc;
          state_nx = S_FETCH;
        end
      end

      S_MEM_REQ: begin
        bus.lsu_req_valid = 1'b1;
        if (bus.lsu_req_ready) begin
          state_nx    = S_MEM_WAIT;
          wait_cnt_nx = '0;
        end
      end

      S_MEM_WAIT: begin
        if (bus.lsu_rsp_valid) begin
          gpr_wen  = mem_wen_q;
          pc_nx    = mem_dnpc_q;
          state_nx = S_FETCH;
        end else if (timeout_hit) begin
          state_nx = S_ERR;
        end else begin
          wait_cnt_nx = wait_cnt + 32'd1;
        end
      end

      S_HALT, S_ERR: bus.ifu_addr = '0;

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      wait_cnt   <= '0;
      mem_wen_q  <= 1'b0;
      mem_dnpc_q <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      inst       <= inst_nx;
      wait_cnt   <= wait_cnt_nx;
      mem_wen_q  <= mem_wen_nx;
      mem_dnpc_q <= mem_dnpc_nx;
    end
  end

  assign halt = (state == S_HALT);
  assign err  = (state == S_ERR);

`ifdef YSYX_23060201_PERF_CNT_EN
  logic [63:0] cycle_q;
  logic [63:0] instret_q;
  logic        active;
  logic        commit;

  assign active = (state != S_IDLE) && (state != S_HALT) && (state != S_ERR);
  assign commit = ((state == S_EXEC) && !is_ebreak && (exu_dnpc[1:0] == 2'b00) && !is_mem) ||
                  ((state == S_MEM_WAIT) && bus.lsu_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (active) cycle_q <= cycle_q + 64'd1;
      if (commit) instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060201_seq_ctrl.sv
// Self-checking bench: transaction-level timing model of the sequencer, randomized bus delays.
module tb_ysyx_23060201_seq_ctrl;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          TIMEOUT  = 16;
`ifdef YSYX_23060201_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int K_ALU      = 0;
  localparam int K_LOAD     = 1;
  localparam int K_STORE    = 2;
  localparam int K_EBREAK   = 3;
  localparam int K_MISALIGN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        is_mem, is_store, is_ebreak, exu_wen;
  logic [31:0] exu_dnpc;
  logic        gpr_wen;
  logic [31:0] pc;
  logic        halt, err;
  logic [63:0] cycle_cnt, instret_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0]     m_pc;
  longint unsigned m_cyc;
  longint unsigned m_ret;

  always #5 clk = ~clk;

  ysyx_23060201_seq_ctrl_if bus ();

  ysyx_23060201_seq_ctrl #(
    .RESET_PC    (RESET_PC),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .inst        (inst),
    .is_mem      (is_mem),
    .is_store    (is_store),
    .is_ebreak   (is_ebreak),
    .exu_wen     (exu_wen),
    .exu_dnpc    (exu_dnpc),
    .gpr_wen     (gpr_wen),
    .pc          (pc),
    .halt        (halt),
    .err         (err),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  task automatic quiet_inputs();
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_data  = '0;
    bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
    is_mem = 1'b0; is_store = 1'b0; is_ebreak = 1'b0; exu_wen = 1'b0;
    exu_dnpc = '0;
  endtask

  // Resets, checks the IDLE cycle, and returns at the start of the first FETCH cycle.
  task automatic test_reset();
    @(negedge clk);
    quiet_inputs();
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
    checks++; if ({halt, err, gpr_wen, bus.ifu_req_valid, bus.lsu_req_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {halt, err, gpr_wen, bus.ifu_req_valid, bus.lsu_req_valid});
    end
    checks++; if ({cycle_cnt, instret_cnt} !== 128'h0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, instret_cnt);
    end
    rst = 1'b0;
    #1;
    checks++; if (bus.ifu_req_valid !== 1'b0) begin errors++; $display("FAIL idle_no_fetch: got %b want 0", bus.ifu_req_valid); end
    m_pc = RESET_PC; m_cyc = 0; m_ret = 0;
    @(negedge clk);
  endtask

  // Runs one instruction from its first FETCH cycle with bus responses scheduled from the delays.
  task automatic exec_inst(input int kind, input int ird, input int rsp, input int mrd, input int mrsp,
                           input logic [31:0] dnpc, input logic wen, input bit abort);
    logic [31:0] word;
    bit   mem;
    int   fetch_len, exec_idx, mreq0, mwait0, total;
    logic exp_wen, exp_ifv, exp_lsv, exp_gw;
    word      = $urandom;
    mem       = (kind == K_LOAD) || (kind == K_STORE);
    fetch_len = ird + 1;
    exec_idx  = fetch_len + rsp + 1;
    mreq0     = exec_idx + 1;
    mwait0    = mreq0 + mrd + 1;
    total     = mem ? (mwait0 + mrsp + 1) : (exec_idx + 1);
    exp_wen   = ((kind == K_ALU) || (kind == K_LOAD)) ? wen : 1'b0;
    is_mem    = mem;
    is_store  = (kind == K_STORE);
    is_ebreak = (kind == K_EBREAK);
    exu_wen   = wen;
    exu_dnpc  = dnpc;
    for (int c = 0; c < total; c++) begin
      bus.ifu_req_ready = (c < fetch_len) ? 1'(c == ird) : 1'($urandom_range(0, 1));
      if (c == exec_idx - 1) bus.ifu_rsp_valid = 1'b1;
      else if (c >= fetch_len && c < exec_idx - 1) bus.ifu_rsp_valid = 1'b0;
      else bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
      bus.ifu_rsp_data  = (c == exec_idx - 1) ? word : $urandom;
      bus.lsu_req_ready = (mem && c >= mreq0 && c < mwait0) ? 1'(c == mreq0 + mrd) : 1'($urandom_range(0, 1));
      if (!mem || c < mwait0) bus.lsu_rsp_valid = 1'($urandom_range(0, 1));
      else bus.lsu_rsp_valid = 1'(c == total - 1);
      if (abort && c == mwait0) begin
        bus.lsu_rsp_valid = 1'b0;
        rst = 1'b1;
      end
      #1;
      exp_ifv = 1'(c < fetch_len);
      exp_lsv = 1'(mem && c >= mreq0 && c < mwait0);
      exp_gw  = (c == total - 1 && !abort) ? exp_wen : 1'b0;
      if (c == 0) begin
        checks++; if (pc !== m_pc) begin errors++; $display("FAIL pc_start: got %h want %h", pc, m_pc); end
        checks++; if (cycle_cnt !== (PERF ? m_cyc : 64'd0)) begin
          errors++; $display("FAIL cycle_cnt: got %0d want %0d", cycle_cnt, PERF ? m_cyc : 64'd0);
        end
        checks++; if (instret_cnt !== (PERF ? m_ret : 64'd0)) begin
          errors++; $display("FAIL instret_cnt: got %0d want %0d", instret_cnt, PERF ? m_ret : 64'd0);
        end
      end
      if (c == ird) begin
        checks++; if (bus.ifu_addr !== m_pc) begin errors++; $display("FAIL ifu_addr: got %h want %h", bus.ifu_addr, m_pc); end
      end
      if (c == exec_idx) begin
        checks++; if (inst !== word) begin errors++; $display("FAIL inst_latch: got %h want %h", inst, word); end
      end
      checks++; if (bus.ifu_req_valid !== exp_ifv) begin
        errors++; $display("FAIL ifu_req_valid c=%0d kind=%0d: got %b want %b", c, kind, bus.ifu_req_valid, exp_ifv);
      end
      checks++; if (bus.lsu_req_valid !== exp_lsv) begin
        errors++; $display("FAIL lsu_req_valid c=%0d kind=%0d: got %b want %b", c, kind, bus.lsu_req_valid, exp_lsv);
      end
      checks++; if (gpr_wen !== exp_gw) begin
        errors++; $display("FAIL gpr_wen c=%0d kind=%0d: got %b want %b", c, kind, gpr_wen, exp_gw);
      end
      @(negedge clk);
      if (abort && c == mwait0) return;
    end
    m_cyc += longint'(total);
    if (kind == K_ALU || mem) begin
      m_pc = dnpc;
      m_ret++;
    end
  endtask

  task automatic test_addi_jal();
    test_reset();
    exec_inst(K_ALU, 0, 0, 0, 0, m_pc + 32'd4, 1'b1, 1'b0);
    #1;
    checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL addi_pc: got %h want 80000004", pc); end
    exec_inst(K_ALU, 0, 0, 0, 0, 32'h8000_0010, 1'b1, 1'b0);
    exec_inst(K_ALU, 1, 2, 0, 0, m_pc + 32'd4, 1'b0, 1'b0);
    exec_inst(K_MISALIGN, 0, 0, 0, 0, 32'h8000_0012, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.ifu_req_ready = 1'b1; bus.ifu_rsp_valid = 1'b1; bus.lsu_rsp_valid = 1'b1;
      #1;
      checks++; if ({err, halt, gpr_wen, bus.ifu_req_valid} !== 4'b1000) begin
        errors++; $display("FAIL misalign_err: got %b want 1000", {err, halt, gpr_wen, bus.ifu_req_valid});
      end
      checks++; if (pc !== 32'h8000_0014) begin errors++; $display("FAIL misalign_pc: got %h want 80000014", pc); end
      @(negedge clk);
    end
  endtask

  task automatic test_mem();
    test_reset();
    exec_inst(K_LOAD, 0, 0, 2, 0, m_pc + 32'd4, 1'b1, 1'b0);
    exec_inst(K_STORE, 0, 0, 2, 0, m_pc + 32'd4, 1'b1, 1'b0);
    exec_inst(K_ALU, 0, 0, 0, 0, m_pc + 32'd4, 1'b1, 1'b0);
  endtask

  task automatic test_watchdog();
    test_reset();
    exec_inst(K_ALU, 0, TIMEOUT - 1, 0, 0, m_pc + 32'd4, 1'b1, 1'b0);
    exec_inst(K_LOAD, 2, 0, 1, TIMEOUT - 1, m_pc + 32'd8, 1'b1, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL boundary_no_err: got %b want 0", err); end
    test_reset();
    for (int c = 0; c < 20; c++) begin
      quiet_inputs();
      bus.ifu_req_ready = 1'(c == 0);
      #1;
      checks++; if (err !== 1'(c >= 1 + TIMEOUT)) begin
        errors++; $display("FAIL watchdog_err c=%0d: got %b want %b", c, err, 1'(c >= 1 + TIMEOUT));
      end
      checks++; if (bus.ifu_req_valid !== 1'(c == 0)) begin
        errors++; $display("FAIL watchdog_ifv c=%0d: got %b want %b", c, bus.ifu_req_valid, 1'(c == 0));
      end
      @(negedge clk);
    end
    #1;
    checks++; if ({bus.ifu_addr, gpr_wen, bus.lsu_req_valid} !== 34'h0) begin
      errors++; $display("FAIL err_outputs: got %h want 0", {bus.ifu_addr, gpr_wen, bus.lsu_req_valid});
    end
  endtask

  task automatic test_random();
    int kind;
    logic [31:0] dn;
    test_reset();
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      dn   = $urandom & 32'hFFFF_FFFC;
      exec_inst(kind, int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), dn, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_ebreak();
    logic [31:0] pc_before;
    pc_before = m_pc;
    exec_inst(K_EBREAK, 1, 1, 0, 0, m_pc + 32'd4, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus.ifu_req_ready = 1'($urandom_range(0, 1)); bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
      bus.lsu_req_ready = 1'($urandom_range(0, 1)); bus.lsu_rsp_valid = 1'($urandom_range(0, 1));
      #1;
      checks++; if ({halt, err, bus.ifu_req_valid, bus.lsu_req_valid, gpr_wen} !== 5'b10000) begin
        errors++; $display("FAIL halt_state i=%0d: got %b want 10000", i, {halt, err, bus.ifu_req_valid, bus.lsu_req_valid, gpr_wen});
      end
      checks++; if (pc !== pc_before || bus.ifu_addr !== 32'h0) begin
        errors++; $display("FAIL halt_pc i=%0d: got pc=%h addr=%h want pc=%h addr=0", i, pc, bus.ifu_addr, pc_before);
      end
      @(negedge clk);
    end
    #1;
    checks++; if (cycle_cnt !== (PERF ? m_cyc : 64'd0)) begin
      errors++; $display("FAIL halt_cycle_cnt: got %0d want %0d", cycle_cnt, PERF ? m_cyc : 64'd0);
    end
  endtask

  task automatic test_reset_mid_mem();
    test_reset();
    exec_inst(K_ALU, 0, 0, 0, 0, m_pc + 32'd4, 1'b1, 1'b0);
    exec_inst(K_LOAD, 0, 1, 1, 3, 32'h8000_0100, 1'b1, 1'b1);
    rst = 1'b0;
    bus.lsu_rsp_valid = 1'b1;
    #1;
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL abort_pc: got %h want %h", pc, RESET_PC); end
    checks++; if ({gpr_wen, bus.ifu_req_valid, bus.lsu_req_valid, halt, err} !== 5'b0) begin
      errors++; $display("FAIL abort_idle: got %b want 00000", {gpr_wen, bus.ifu_req_valid, bus.lsu_req_valid, halt, err});
    end
    checks++; if (instret_cnt !== 64'd0) begin errors++; $display("FAIL abort_instret: got %0d want 0", instret_cnt); end
    m_pc = RESET_PC; m_cyc = 0; m_ret = 0;
    @(negedge clk);
    exec_inst(K_ALU, 0, 0, 0, 0, m_pc + 32'd4, 1'b1, 1'b0);
  endtask

  task automatic test_perf();
    test_reset();
    for (int i = 0; i < 10; i++) exec_inst(K_ALU, 0, 0, 0, 0, m_pc + 32'd4, 1'b1, 1'b0);
    #1;
    checks++; if (instret_cnt !== (PERF ? 64'd10 : 64'd0)) begin
      errors++; $display("FAIL perf_instret: got %0d want %0d", instret_cnt, PERF ? 10 : 0);
    end
    checks++; if (cycle_cnt !== (PERF ? 64'd30 : 64'd0)) begin
      errors++; $display("FAIL perf_cycles: got %0d want %0d", cycle_cnt, PERF ? 30 : 0);
    end
    checks++; if (pc !== RESET_PC + 32'd40) begin errors++; $display("FAIL perf_pc: got %h want %h", pc, RESET_PC + 32'd40); end
  endtask

  initial begin
    rst = 1'b1;
    quiet_inputs();
    test_reset();
    test_addi_jal();
    test_mem();
    test_watchdog();
    test_random();
    test_ebreak();
    test_reset_mid_mem();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
